uart_rx_fifo: RTL

- Receive-side buffer placed directly downstream of the UART receiver.
- Detects each completed frame from the receiver's busy/data/error outputs and stores the data byte plus its error flag in a first-word-fall-through FIFO.
- Presents the stored entries to the system on a valid/ready read interface.
- Tracks FIFO overflow and counts frames received with errors.

---
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side buffer placed directly behind a UART receiver. Each completed
// frame is detected as a falling edge of the receiver's busy flag. The data
// byte and its error flag are stored in a first-word-fall-through FIFO and
// handed to the system over a valid/ready read interface. The block also keeps
// a sticky overflow flag and a saturating count of errored frames.
//
// Parameters
//   G_WORD_WIDTH  data bits per frame (must match the receiver)
//   G_DEPTH       FIFO entries, power of two, >= 2
//   G_DROP_ERR    1 = errored frames are counted but not stored
//                 0 = errored frames are stored with their error flag
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_rx_busy         receiver busy; a 1->0 transition completes a frame
//   i_rx_data         receiver data, sampled only in the completion cycle
//   i_rx_error        receiver error, sampled only in the completion cycle
//   o_rd_data         head-of-FIFO data
//   o_rd_err          head-of-FIFO error flag
//   o_rd_valid        FIFO not empty
//   i_rd_ready        consumer takes the head entry when o_rd_valid=1
//   o_level           number of stored entries, 0..G_DEPTH
//   o_overflow        sticky; a frame was lost because the FIFO was full
//   i_clr_overflow    clears o_overflow (a simultaneous set wins)
//   o_err_count       errored-frame count, saturates at 255

module uart_rx_fifo #(
    parameter int G_WORD_WIDTH = 8,
    parameter int G_DEPTH      = 16,
    parameter bit G_DROP_ERR   = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx_busy,
    input  logic [G_WORD_WIDTH-1:0]   i_rx_data,
    input  logic                      i_rx_error,
    output logic [G_WORD_WIDTH-1:0]   o_rd_data,
    output logic                      o_rd_err,
    output logic                      o_rd_valid,
    input  logic                      i_rd_ready,
    output logic [$clog2(G_DEPTH):0]  o_level,
    output logic                      o_overflow,
    input  logic                      i_clr_overflow,
    output logic [7:0]                o_err_count
);

    localparam int AW = $clog2(G_DEPTH);
    localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(G_DEPTH);

    logic                    r_busy_d;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_level;
    logic                    r_overflow;
    logic [7:0]              r_err_count;
    logic [G_WORD_WIDTH:0]   mem [G_DEPTH];

    logic evt;
    logic push_req;
    logic pop;
    logic full;
    logic push;

    always_comb begin
        evt      = r_busy_d & ~i_rx_busy;
        push_req = evt & ~(G_DROP_ERR & i_rx_error);
        pop      = o_rd_valid & i_rd_ready;
        full     = (r_level == C_FULL_LEVEL);
        // A pop in the same cycle frees the head slot, so a full FIFO can
        // still take the new frame.
        push     = push_req & (~full | pop);
    end

    // Storage is deliberately not reset; the head is only meaningful while
    // o_rd_valid is high. When full with a simultaneous pop, wr_ptr equals
    // rd_ptr and the entry being overwritten is the one leaving this cycle.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[r_wr_ptr] <= {i_rx_error, i_rx_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy_d    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_busy_d <= i_rx_busy;

            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase

            // Set has priority over clear so a loss in the clear cycle is
            // never hidden.
            if (push_req && full && !pop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end

            if (evt && i_rx_error && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_rd_valid             = (r_level != '0);
    assign {o_rd_err, o_rd_data}  = mem[r_rd_ptr];
    assign o_level                = r_level;
    assign o_overflow             = r_overflow;
    assign o_err_count            = r_err_count;

endmodule
